// File: rtl/snake_frame_writer.sv
// snake_frame_writer: serialises one snake frame into grid-write beats.
// A start pulse captures the snake, food and tail-erase cell, then beats
// are emitted over valid/ready in the order erase, head, body..., food,
// followed by a one-cycle done pulse.
module snake_frame_writer #(
   parameter int COORD_W = 4,
   parameter int MAX_SEG = 10,
   parameter int LEN_W   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [MAX_SEG*2*COORD_W-1:0] snake_in,
   input  logic [LEN_W-1:0]             seg_count,
   input  logic [COORD_W-1:0]           xfood,
   input  logic [COORD_W-1:0]           yfood,
   input  logic                         erase_en,
   input  logic [COORD_W-1:0]           erase_x,
   input  logic [COORD_W-1:0]           erase_y,
   input  logic                         wr_ready,
   output logic                         wr_valid,
   output logic [COORD_W-1:0]           x_loc,
   output logic [COORD_W-1:0]           y_loc,
   output logic [1:0]                   data_out,
   output logic                         busy,
   output logic                         done
);

   localparam int SEG_W   = 2 * COORD_W;
   localparam int SNAKE_W = MAX_SEG * SEG_W;
   localparam int IDX_W   = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_SEG);

   localparam logic [1:0] CODE_EMPTY = 2'b00;
   localparam logic [1:0] CODE_FOOD  = 2'b01;
   localparam logic [1:0] CODE_BODY  = 2'b10;
   localparam logic [1:0] CODE_HEAD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_HEAD,
      S_BODY,
      S_FOOD,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [SNAKE_W-1:0]   snake_q;
   logic [LEN_W-1:0]     count_q;
   logic [COORD_W-1:0]   xfood_q;
   logic [COORD_W-1:0]   yfood_q;
   logic [COORD_W-1:0]   erase_x_q;
   logic [COORD_W-1:0]   erase_y_q;
   logic [IDX_W-1:0]     idx_q;

   logic [LEN_W-1:0]     count_d;
   logic [IDX_W-1:0]     idx_inc;
   logic [SEG_W-1:0]     head_in;
   logic [SEG_W-1:0]     head_q;
   logic [SEG_W-1:0]     next_seg_q;
   logic                 last_body;

   // Segment k of a packed snake vector: {y, x}.
   function automatic logic [SEG_W-1:0] seg_at(input logic [SNAKE_W-1:0] v,
                                                input logic [IDX_W-1:0]   k);
      return v[int'(k)*SEG_W +: SEG_W];
   endfunction

   // Clamped length, segment lookups and the end-of-body test.
   always_comb begin
      count_d    = (seg_count > MAX_CNT) ? MAX_CNT : seg_count;
      idx_inc    = idx_q + IDX_W'(1);
      head_in    = seg_at(snake_in, '0);
      head_q     = seg_at(snake_q, '0);
      next_seg_q = seg_at(snake_q, idx_inc);
      last_body  = (LEN_W'(idx_inc) == count_q);
   end

   // Frame sequencer; every output is loaded together with the state that owns it.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, regardless of statement order in this block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the captured frame copy is reset along with the control state;
         // it is small, and a defined value keeps the beat outputs clean.
         state_q   <= S_IDLE;
         snake_q   <= '0;
         count_q   <= '0;
         xfood_q   <= '0;
         yfood_q   <= '0;
         erase_x_q <= '0;
         erase_y_q <= '0;
         idx_q     <= '0;
         wr_valid  <= 1'b0;
         x_loc     <= '0;
         y_loc     <= '0;
         data_out  <= CODE_EMPTY;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  snake_q   <= snake_in;
                  count_q   <= count_d;
                  xfood_q   <= xfood;
                  yfood_q   <= yfood;
                  erase_x_q <= erase_x;
                  erase_y_q <= erase_y;
                  idx_q     <= '0;
                  busy      <= 1'b1;
                  wr_valid  <= 1'b1;
                  // First beat comes straight from the inputs being captured.
                  if (erase_en) begin
                     state_q  <= S_ERASE;
                     x_loc    <= erase_x;
                     y_loc    <= erase_y;
                     data_out <= CODE_EMPTY;
                  end else if (count_d != '0) begin
                     state_q  <= S_HEAD;
                     x_loc    <= head_in[COORD_W-1:0];
                     y_loc    <= head_in[SEG_W-1:COORD_W];
                     data_out <= CODE_HEAD;
                  end else begin
                     state_q  <= S_FOOD;
                     x_loc    <= xfood;
                     y_loc    <= yfood;
                     data_out <= CODE_FOOD;
                  end
               end
            end
            S_ERASE: begin
               if (wr_ready) begin
                  if (count_q != '0) begin
                     state_q  <= S_HEAD;
                     x_loc    <= head_q[COORD_W-1:0];
                     y_loc    <= head_q[SEG_W-1:COORD_W];
                     data_out <= CODE_HEAD;
                  end else begin
                     state_q  <= S_FOOD;
                     x_loc    <= xfood_q;
                     y_loc    <= yfood_q;
                     data_out <= CODE_FOOD;
                  end
               end
            end
            S_HEAD: begin
               if (wr_ready) begin
                  idx_q <= idx_inc;
                  if (count_q > LEN_W'(1)) begin
                     state_q  <= S_BODY;
                     x_loc    <= next_seg_q[COORD_W-1:0];
                     y_loc    <= next_seg_q[SEG_W-1:COORD_W];
                     data_out <= CODE_BODY;
                  end else begin
                     state_q  <= S_FOOD;
                     x_loc    <= xfood_q;
                     y_loc    <= yfood_q;
                     data_out <= CODE_FOOD;
                  end
               end
            end
            S_BODY: begin
               if (wr_ready) begin
                  // Index stops at count-1 so it never points past the snake.
                  if (last_body) begin
                     state_q  <= S_FOOD;
                     x_loc    <= xfood_q;
                     y_loc    <= yfood_q;
                     data_out <= CODE_FOOD;
                  end else begin
                     idx_q    <= idx_inc;
                     x_loc    <= next_seg_q[COORD_W-1:0];
                     y_loc    <= next_seg_q[SEG_W-1:COORD_W];
                     data_out <= CODE_BODY;
                  end
               end
            end
            S_FOOD: begin
               if (wr_ready) begin
                  state_q  <= S_DONE;
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q  <= S_IDLE;
               wr_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_frame_writer.sv
// Self-checking bench for snake_frame_writer: directed frames plus random
// frames with random back-pressure, checked against a beat-list model.
module tb_snake_frame_writer;

   localparam int CW = 4;
   localparam int MS = 10;
   localparam int LW = 4;
   localparam int SW = MS * 2 * CW;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [SW-1:0]  snake_in = '0;
   logic [LW-1:0]  seg_count = '0;
   logic [CW-1:0]  xfood = '0;
   logic [CW-1:0]  yfood = '0;
   logic           erase_en = 1'b0;
   logic [CW-1:0]  erase_x = '0;
   logic [CW-1:0]  erase_y = '0;
   logic           wr_ready = 1'b1;
   logic           wr_valid;
   logic [CW-1:0]  x_loc;
   logic [CW-1:0]  y_loc;
   logic [1:0]     data_out;
   logic           busy;
   logic           done;

   snake_frame_writer #(.COORD_W(CW), .MAX_SEG(MS), .LEN_W(LW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .snake_in (snake_in),
      .seg_count(seg_count),
      .xfood    (xfood),
      .yfood    (yfood),
      .erase_en (erase_en),
      .erase_x  (erase_x),
      .erase_y  (erase_y),
      .wr_ready (wr_ready),
      .wr_valid (wr_valid),
      .x_loc    (x_loc),
      .y_loc    (y_loc),
      .data_out (data_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   logic [CW-1:0]     sx [MS];
   logic [CW-1:0]     sy [MS];
   logic [2*CW+1:0]   exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Place the coordinate arrays into the packed snake bus.
   task automatic pack_snake();
      for (int k = 0; k < MS; k++) snake_in[k*2*CW +: 2*CW] = {sy[k], sx[k]};
   endtask

   task automatic random_snake();
      for (int k = 0; k < MS; k++) begin
         sx[k] = CW'($urandom);
         sy[k] = CW'($urandom);
      end
   endtask

   // Drive junk on every frame input so only the captured copy can be used.
   task automatic scramble();
      for (int k = 0; k < MS; k++) snake_in[k*2*CW +: 2*CW] = (2*CW)'($urandom);
      seg_count = LW'($urandom);
      xfood     = CW'($urandom);
      yfood     = CW'($urandom);
      erase_en  = 1'($urandom);
      erase_x   = CW'($urandom);
      erase_y   = CW'($urandom);
   endtask

   // Expected beat list {x, y, code}: erase?, head, bodies, food.
   task automatic build_expect(input bit er, input logic [CW-1:0] ex, input logic [CW-1:0] ey,
                               input int cnt, input logic [CW-1:0] fx, input logic [CW-1:0] fy);
      int n;
      exp_q.delete();
      n = (cnt > MS) ? MS : cnt;
      if (er) exp_q.push_back({ex, ey, 2'b00});
      for (int k = 0; k < n; k++) exp_q.push_back({sx[k], sy[k], (k == 0) ? 2'b11 : 2'b10});
      exp_q.push_back({fx, fy, 2'b01});
   endtask

   task automatic run_frame(input string tag, input bit er, input logic [CW-1:0] ex,
                            input logic [CW-1:0] ey, input int cnt, input logic [CW-1:0] fx,
                            input logic [CW-1:0] fy, input int stall_at, input int stall_len,
                            input bit rnd_bp, input bit mid_start);
      int              bi;
      int              stalls;
      int              left;
      int              cyc;
      bit              was_stalled;
      bit              got_done;
      bit              stall_now;
      logic [2*CW+1:0] beat;
      logic [2*CW+1:0] held;

      build_expect(er, ex, ey, cnt, fx, fy);
      @(negedge clk);
      pack_snake();
      erase_en  = er;
      erase_x   = ex;
      erase_y   = ey;
      seg_count = LW'(cnt);
      xfood     = fx;
      yfood     = fy;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();

      bi = 0; stalls = 0; left = stall_len; cyc = 1;
      was_stalled = 1'b0; got_done = 1'b0; held = '0;
      while (!got_done && cyc <= 200) begin
         if (cyc == 1) begin
            check({tag, " busy@1"}, 32'(busy), 32'd1);
            check({tag, " valid@1"}, 32'(wr_valid), 32'd1);
         end
         if (mid_start && cyc == 2) begin
            start = 1'b1;
            snake_in = ~snake_in;
            seg_count = LW'(MS);
         end
         if (mid_start && cyc == 3) start = 1'b0;
         if (done) begin
            got_done = 1'b1;
         end else begin
            beat = {x_loc, y_loc, data_out};
            if (was_stalled) check({tag, " stall hold"}, 32'(beat), 32'(held));
            if (!wr_valid) begin
               check({tag, " no bubble"}, 32'(wr_valid), 32'd1);
               wr_ready = 1'b1;
               was_stalled = 1'b0;
            end else begin
               stall_now = 1'b0;
               if (bi == stall_at && left > 0) begin
                  stall_now = 1'b1;
                  left--;
               end else if (rnd_bp && $urandom_range(0, 2) == 0) begin
                  stall_now = 1'b1;
               end
               if (stall_now) begin
                  wr_ready = 1'b0;
                  stalls++;
                  was_stalled = 1'b1;
                  held = beat;
               end else begin
                  wr_ready = 1'b1;
                  was_stalled = 1'b0;
                  if (bi < exp_q.size()) check($sformatf("%s beat%0d", tag, bi), 32'(beat), 32'(exp_q[bi]));
                  else check({tag, " extra beat"}, 32'(bi), 32'(exp_q.size()));
                  bi++;
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      wr_ready = 1'b1;
      check({tag, " done seen"}, 32'(got_done), 32'd1);
      check({tag, " beat count"}, 32'(bi), 32'(exp_q.size()));
      check({tag, " latency"}, 32'(cyc), 32'(exp_q.size() + 1 + stalls));
      check({tag, " busy@done"}, 32'(busy), 32'd0);
      check({tag, " valid@done"}, 32'(wr_valid), 32'd0);
      @(negedge clk);
      check({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      // Reset values.
      @(negedge clk);
      check("rst valid", 32'(wr_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst xy", 32'({x_loc, y_loc}), 32'd0);
      check("rst code", 32'(data_out), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Basic 3-segment frame at full rate.
      sx[0] = 4'd5; sy[0] = 4'd5;
      sx[1] = 4'd4; sy[1] = 4'd5;
      sx[2] = 4'd3; sy[2] = 4'd5;
      for (int k = 3; k < MS; k++) begin sx[k] = 4'd0; sy[k] = 4'd0; end
      run_frame("basic", 1'b0, 4'd0, 4'd0, 3, 4'd9, 4'd2, -1, 0, 1'b0, 1'b0);

      // Erase cell plus 3 stall cycles on the head beat.
      run_frame("erase_bp", 1'b1, 4'd2, 4'd5, 3, 4'd9, 4'd2, 1, 3, 1'b0, 1'b0);

      // Length corner cases.
      random_snake();
      run_frame("len0", 1'b0, 4'd1, 4'd1, 0, 4'd7, 4'd8, -1, 0, 1'b0, 1'b0);
      run_frame("len0_er", 1'b1, 4'd3, 4'd4, 0, 4'd7, 4'd8, -1, 0, 1'b0, 1'b0);
      run_frame("len1", 1'b0, 4'd1, 4'd1, 1, 4'd6, 4'd3, -1, 0, 1'b0, 1'b0);
      random_snake();
      run_frame("len12", 1'b0, 4'd1, 4'd1, 12, 4'd2, 4'd14, -1, 0, 1'b0, 1'b0);
      run_frame("len10_er", 1'b1, 4'd15, 4'd0, 10, 4'd2, 4'd14, -1, 0, 1'b0, 1'b0);

      // Start while busy is ignored and not queued.
      random_snake();
      run_frame("mid_start", 1'b0, 4'd0, 4'd0, 5, 4'd11, 4'd12, -1, 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("no 2nd frame valid", 32'(wr_valid), 32'd0);
         check("no 2nd frame busy", 32'(busy), 32'd0);
         @(negedge clk);
      end

      // Reset in the middle of a 5-segment frame.
      random_snake();
      pack_snake();
      seg_count = 4'd5; erase_en = 1'b0; xfood = 4'd1; yfood = 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("pre-rst valid", 32'(wr_valid), 32'd1);
      reset = 1'b0;
      #1;
      check("async valid", 32'(wr_valid), 32'd0);
      check("async busy", 32'(busy), 32'd0);
      check("async code", 32'(data_out), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst no done", 32'(done), 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      check("post-rst idle", 32'(busy), 32'd0);
      random_snake();
      run_frame("post_rst", 1'b0, 4'd0, 4'd0, 5, 4'd3, 4'd9, -1, 0, 1'b0, 1'b0);

      // Random frames with random back-pressure.
      for (int f = 0; f < 24; f++) begin
         random_snake();
         run_frame($sformatf("rnd%0d", f), 1'($urandom), CW'($urandom), CW'($urandom),
                   int'($urandom_range(0, 15)), CW'($urandom), CW'($urandom),
                   -1, 0, 1'b1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
